// File: rtl/mgmt_wb_pkg.sv
// Shared types and defaults for the management Wishbone target mux.
// Holds the FSM state enum, the Caravel address map and a clog2 helper.
package mgmt_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_e;

  localparam logic [31:0] ERR_DATA_DEF = 32'hBADD_0000;

  localparam logic [31:0] MPRJ_BASE  = 32'h3000_0000;
  localparam logic [31:0] MPRJ_MASK  = 32'hF000_0000;
  localparam logic [31:0] HK_BASE    = 32'h2600_0000;
  localparam logic [31:0] HK_MASK    = 32'hFFF0_0000;
  localparam logic [31:0] SPARE_BASE = 32'h2610_0000;
  localparam logic [31:0] SPARE_MASK = 32'hFFF0_0000;

  localparam logic [95:0] DEF_TGT_BASE =
    {SPARE_BASE, HK_BASE, MPRJ_BASE};
  localparam logic [95:0] DEF_TGT_MASK =
    {SPARE_MASK, HK_MASK, MPRJ_MASK};

  // Index width for v entries; never below one bit.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mgmt_wb_addr_decode.sv
// Combinational priority address decoder; lowest enabled match wins.
// Ports: adr_i/iena_i in; hit_o and binary idx_o out.
module mgmt_wb_addr_decode
  import mgmt_wb_pkg::*;
#(
  parameter int             N    = 3,
  parameter logic [N*32-1:0] BASE = DEF_TGT_BASE,
  parameter logic [N*32-1:0] MASK = DEF_TGT_MASK,
  localparam int            IW   = clog2(N)
) (
  input  logic [31:0]   adr_i,
  input  logic [N-1:0]  iena_i,
  output logic          hit_o,
  output logic [IW-1:0] idx_o
);

  // Scan from the top so the lowest index is written last.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (((adr_i & MASK[i*32 +: 32]) == BASE[i*32 +: 32])
          && iena_i[i]) begin
        hit_o = 1'b1;
        idx_o = IW'(i);
      end
    end
  end

endmodule

// File: rtl/mgmt_wb_target_mux.sv
// Wishbone classic mux: one master to N_TGT targets, registered request,
// error on unmapped/disabled address, ack timeout with saturating counter.
// Ports: m_* master side, t_* target side, timeout_* and last_err_adr_o status.
module mgmt_wb_target_mux
  import mgmt_wb_pkg::*;
#(
  parameter int                  N_TGT       = 3,
  parameter logic [N_TGT*32-1:0] TGT_BASE    = DEF_TGT_BASE,
  parameter logic [N_TGT*32-1:0] TGT_MASK    = DEF_TGT_MASK,
  parameter int                  TIMEOUT_CYC = 255,
  parameter logic [31:0]         ERR_DATA    = ERR_DATA_DEF
) (
  input  logic                  core_clk,
  input  logic                  core_rst,
  input  logic                  m_cyc_i,
  input  logic                  m_stb_i,
  input  logic                  m_we_i,
  input  logic [3:0]            m_sel_i,
  input  logic [31:0]           m_adr_i,
  input  logic [31:0]           m_dat_i,
  output logic                  m_ack_o,
  output logic                  m_err_o,
  output logic [31:0]           m_dat_o,
  output logic [N_TGT-1:0]      t_cyc_o,
  output logic [N_TGT-1:0]      t_stb_o,
  output logic                  t_we_o,
  output logic [3:0]            t_sel_o,
  output logic [31:0]           t_adr_o,
  output logic [31:0]           t_dat_o,
  input  logic [N_TGT-1:0]      t_ack_i,
  input  logic [N_TGT*32-1:0]   t_dat_i,
  input  logic [N_TGT-1:0]      t_iena_i,
  input  logic                  timeout_clr_i,
  output logic [7:0]            timeout_cnt_o,
  output logic [31:0]           last_err_adr_o
);

  localparam int          IW       = clog2(N_TGT);
  // Last wait count before timeout: strobe is high TIMEOUT_CYC cycles.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  state_e            state_q;
  logic [IW-1:0]     tgt_q;
  logic [15:0]       wait_q;
  logic [N_TGT-1:0]  stb_q;
  logic              we_q;
  logic [3:0]        sel_q;
  logic [31:0]       adr_q;
  logic [31:0]       wdat_q;
  logic              ack_q;
  logic              err_q;
  logic [31:0]       rdat_q;
  logic [7:0]        cnt_q;
  logic [7:0]        cnt_d;
  logic [31:0]       lerr_q;

  logic              dec_hit;
  logic [IW-1:0]     dec_idx;
  logic [N_TGT-1:0]  dec_oh;
  logic [31:0]       tdat [N_TGT];
  logic              ack_sel;
  logic              iena_sel;
  logic              tmo_hit;

  mgmt_wb_addr_decode #(
    .N    (N_TGT),
    .BASE (TGT_BASE),
    .MASK (TGT_MASK)
  ) u_dec (
    .adr_i  (m_adr_i),
    .iena_i (t_iena_i),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  always_comb begin
    dec_oh = '0;
    dec_oh[dec_idx] = dec_hit;
  end

  always_comb begin
    for (int i = 0; i < N_TGT; i++) begin
      tdat[i] = t_dat_i[i*32 +: 32];
    end
  end

  assign ack_sel  = t_ack_i[tgt_q];
  assign iena_sel = t_iena_i[tgt_q];

  assign tmo_hit = (state_q == REQ) && m_cyc_i && iena_sel
                   && !ack_sel && (wait_q == TMO_LAST);

  // Clear first so a same-cycle timeout still lands as a count of one.
  always_comb begin
    cnt_d = timeout_clr_i ? 8'd0 : cnt_q;
    if (tmo_hit && (cnt_d != 8'hFF)) cnt_d = cnt_d + 8'd1;
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      wait_q  <= '0;
      stb_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
      cnt_q   <= '0;
      lerr_q  <= '0;
    end else begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      rdat_q <= '0;
      cnt_q  <= cnt_d;
      unique case (state_q)
        IDLE: begin
          if (m_cyc_i && m_stb_i) begin
            we_q   <= m_we_i;
            sel_q  <= m_sel_i;
            adr_q  <= m_adr_i;
            wdat_q <= m_dat_i;
            wait_q <= '0;
            if (dec_hit) begin
              tgt_q   <= dec_idx;
              stb_q   <= dec_oh;
              state_q <= REQ;
            end else begin
              err_q   <= 1'b1;
              rdat_q  <= ERR_DATA;
              lerr_q  <= m_adr_i;
              state_q <= ERR;
            end
          end
        end
        REQ: begin
          if (!m_cyc_i) begin
            stb_q   <= '0;
            state_q <= IDLE;
          end else if (!iena_sel || tmo_hit) begin
            stb_q   <= '0;
            err_q   <= 1'b1;
            rdat_q  <= ERR_DATA;
            lerr_q  <= adr_q;
            state_q <= ERR;
          end else if (ack_sel) begin
            stb_q   <= '0;
            ack_q   <= 1'b1;
            rdat_q  <= we_q ? 32'd0 : tdat[tgt_q];
            state_q <= RESP;
          end else begin
            wait_q <= wait_q + 16'd1;
          end
        end
        RESP, ERR: state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  assign m_ack_o        = ack_q;
  assign m_err_o        = err_q;
  assign m_dat_o        = rdat_q;
  assign t_cyc_o        = stb_q;
  assign t_stb_o        = stb_q;
  assign t_we_o         = we_q;
  assign t_sel_o        = sel_q;
  assign t_adr_o        = adr_q;
  assign t_dat_o        = wdat_q;
  assign timeout_cnt_o  = cnt_q;
  assign last_err_adr_o = lerr_q;

endmodule

// File: tb/tb_mgmt_wb_target_mux.sv
// Bench for mgmt_wb_target_mux: transaction-level reference model,
// per-cycle compare, directed scenarios and a randomized run.
module tb_mgmt_wb_target_mux;

  localparam int N = 3;
  localparam int T = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m_cyc, m_stb, m_we;
  logic [3:0]    m_sel;
  logic [31:0]   m_adr, m_wd;
  logic          m_ack, m_err;
  logic [31:0]   m_rd;
  logic [N-1:0]  t_cyc, t_stb;
  logic          t_we;
  logic [3:0]    t_sel;
  logic [31:0]   t_adr, t_wd;
  logic [N-1:0]  t_ack, t_iena;
  logic [N*32-1:0] t_rd;
  logic          clr;
  logic [7:0]    cnt;
  logic [31:0]   lerr;

  always #5 clk = ~clk;

  mgmt_wb_target_mux #(
    .N_TGT       (N),
    .TGT_BASE    ({32'h2610_0000, 32'h2600_0000, 32'h3000_0000}),
    .TGT_MASK    ({32'hFFF0_0000, 32'hFFF0_0000, 32'hF000_0000}),
    .TIMEOUT_CYC (T),
    .ERR_DATA    (32'hBADD_0000)
  ) dut (
    .core_clk       (clk),
    .core_rst       (rst),
    .m_cyc_i        (m_cyc),
    .m_stb_i        (m_stb),
    .m_we_i         (m_we),
    .m_sel_i        (m_sel),
    .m_adr_i        (m_adr),
    .m_dat_i        (m_wd),
    .m_ack_o        (m_ack),
    .m_err_o        (m_err),
    .m_dat_o        (m_rd),
    .t_cyc_o        (t_cyc),
    .t_stb_o        (t_stb),
    .t_we_o         (t_we),
    .t_sel_o        (t_sel),
    .t_adr_o        (t_adr),
    .t_dat_o        (t_wd),
    .t_ack_i        (t_ack),
    .t_dat_i        (t_rd),
    .t_iena_i       (t_iena),
    .timeout_clr_i  (clr),
    .timeout_cnt_o  (cnt),
    .last_err_adr_o (lerr)
  );

  int nerr = 0;
  int nchk = 0;

  function automatic void check(string name, logic [31:0] act,
                                logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: target windows and transaction bookkeeping.
  logic [31:0] bases [N] = '{32'h3000_0000, 32'h2600_0000, 32'h2610_0000};
  logic [31:0] masks [N] = '{32'hF000_0000, 32'hFFF0_0000, 32'hFFF0_0000};

  int          phase = 0;  // 0 free, 1 strobing, 2 responding
  int          mt = 0;     // target being strobed
  int          ms = 0;     // strobe cycles elapsed
  bit          e_ack = 0, e_err = 0, e_we = 0;
  logic [31:0] e_dat = 0, e_adr = 0, e_wd = 0, e_lerr = 0;
  logic [3:0]  e_sel = 0;
  logic [N-1:0] e_stb = 0;
  int          e_cnt = 0;

  function automatic int find_tgt(logic [31:0] a, logic [N-1:0] en);
    for (int i = 0; i < N; i++)
      if (((a & masks[i]) == bases[i]) && en[i]) return i;
    return -1;
  endfunction

  function automatic void model_step();
    bit tmo;
    int h;
    tmo = 0;
    e_ack = 0;
    e_err = 0;
    e_dat = 0;
    if (rst) begin
      phase = 0; e_stb = 0; e_we = 0; e_sel = 0;
      e_adr = 0; e_wd = 0; e_lerr = 0; e_cnt = 0;
      return;
    end
    if (phase == 0) begin
      if (m_cyc && m_stb) begin
        e_we = m_we; e_sel = m_sel; e_adr = m_adr; e_wd = m_wd;
        h = find_tgt(m_adr, t_iena);
        if (h >= 0) begin
          phase = 1; mt = h; ms = 1;
          e_stb = 0; e_stb[h] = 1'b1;
        end else begin
          phase = 2; e_err = 1; e_dat = 32'hBADD_0000; e_lerr = m_adr;
        end
      end
    end else if (phase == 1) begin
      if (!m_cyc) begin
        phase = 0; e_stb = 0;
      end else if (!t_iena[mt]) begin
        phase = 2; e_stb = 0; e_err = 1;
        e_dat = 32'hBADD_0000; e_lerr = e_adr;
      end else if (t_ack[mt]) begin
        phase = 2; e_stb = 0; e_ack = 1;
        e_dat = e_we ? 32'd0 : t_rd[32*mt +: 32];
      end else if (ms == T) begin
        phase = 2; e_stb = 0; e_err = 1; tmo = 1;
        e_dat = 32'hBADD_0000; e_lerr = e_adr;
      end else begin
        ms++;
      end
    end else begin
      phase = 0;
    end
    if (clr) e_cnt = 0;
    if (tmo && e_cnt < 255) e_cnt++;
  endfunction

  function automatic void compare_all();
    check("m_ack", m_ack, e_ack);
    check("m_err", m_err, e_err);
    check("ack_err_excl", m_ack & m_err, 0);
    check("m_dat", m_rd, e_dat);
    check("t_stb", t_stb, e_stb);
    check("t_cyc", t_cyc, e_stb);
    check("t_we", t_we, e_we);
    check("t_sel", t_sel, e_sel);
    check("t_adr", t_adr, e_adr);
    check("t_dat", t_wd, e_wd);
    check("tmo_cnt", cnt, e_cnt);
    check("last_err", lerr, e_lerr);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic req(logic [31:0] a, logic we, logic [31:0] d,
                     logic [3:0] s);
    m_cyc = 1; m_stb = 1; m_we = we; m_adr = a; m_wd = d; m_sel = s;
  endtask

  task automatic idle_m();
    m_cyc = 0; m_stb = 0;
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 5))
      0: return {12'h300, 20'($urandom)};
      1: return {12'h260, 20'($urandom)};
      2: return {12'h261, 20'($urandom)};
      3: return 32'h4000_0000;
      4: return 32'h2620_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit act;
    rst = 1; clr = 0; t_ack = 0; t_iena = '1; t_rd = '0;
    m_cyc = 0; m_stb = 0; m_we = 0; m_sel = 0; m_adr = 0; m_wd = 0;
    tick();
    tick();
    check("reset_stb", t_stb, 0);
    check("reset_err", m_err, 0);
    rst = 0;
    tick();

    // Read, target 0 acks in its first strobe cycle.
    req(32'h3000_0004, 0, 0, 4'hF);
    tick();
    check("rd_stb_c1", t_stb, 3'b001);
    idle_m(); m_cyc = 1; m_stb = 1;
    t_ack = 3'b001; t_rd = {32'h0, 32'h0, 32'h1234_5678};
    tick();
    check("rd_ack_c2", m_ack, 1);
    check("rd_dat_c2", m_rd, 32'h1234_5678);
    t_ack = 0; idle_m();
    tick();

    // Write to target 1, ack after three wait cycles.
    req(32'h2600_0010, 1, 32'hA5A5_A5A5, 4'b0011);
    tick();
    m_adr = $urandom; m_wd = $urandom; m_sel = 4'hC;
    for (int k = 0; k < 3; k++) begin
      check("wr_stb", t_stb, 3'b010);
      check("wr_adr", t_adr, 32'h2600_0010);
      check("wr_dat", t_wd, 32'hA5A5_A5A5);
      check("wr_sel", t_sel, 4'b0011);
      tick();
    end
    t_ack = 3'b010; t_rd = '1;
    tick();
    check("wr_ack", m_ack, 1);
    check("wr_rdat", m_rd, 0);
    t_ack = 0; idle_m();
    tick();
    check("wr_one_ack", m_ack, 0);

    // Unmapped address.
    req(32'h4000_0000, 0, 0, 4'hF);
    tick();
    check("um_err", m_err, 1);
    check("um_dat", m_rd, 32'hBADD_0000);
    check("um_lerr", lerr, 32'h4000_0000);
    check("um_stb", t_stb, 0);
    check("um_cnt", cnt, 0);
    idle_m();
    tick();

    // Timeout on target 2, then a late ack.
    req(32'h2610_0000, 0, 0, 4'hF);
    tick();
    for (int k = 0; k < T; k++) begin
      check("to_stb", t_stb, 3'b100);
      tick();
    end
    check("to_err", m_err, 1);
    check("to_cnt", cnt, 1);
    idle_m();
    t_ack = 3'b100;
    tick();
    check("late_ack", m_ack, 0);
    t_ack = 0;
    tick();

    // Abort in REQ cycle two, then reset in REQ.
    req(32'h3000_0000, 0, 0, 4'hF);
    tick();
    tick();
    idle_m();
    tick();
    check("abort_stb", t_stb, 0);
    check("abort_resp", {m_ack, m_err}, 0);
    req(32'h2600_0000, 1, 32'h55, 4'h1);
    tick();
    rst = 1;
    tick();
    check("rst_outs", |{m_ack, m_err, m_rd, t_cyc, t_stb, t_we,
                       t_sel, t_adr, t_wd, cnt, lerr}, 0);
    rst = 0; idle_m();
    tick();

    // Disabled target.
    t_iena = 3'b110;
    req(32'h3000_0000, 0, 0, 4'hF);
    tick();
    check("dis_err", m_err, 1);
    idle_m(); t_iena = '1;
    tick();

    // Saturate the timeout counter.
    for (int n = 0; n < 257; n++) begin
      req(32'h2610_0040, 0, 0, 4'hF);
      repeat (T + 1) tick();
      idle_m();
      tick();
    end
    check("sat_cnt", cnt, 255);

    // Clear with a simultaneous timeout, then clear alone.
    req(32'h2610_0000, 0, 0, 4'hF);
    repeat (T) tick();
    clr = 1;
    tick();
    check("clr_inc", cnt, 1);
    clr = 0; idle_m();
    tick();
    clr = 1;
    tick();
    check("clr_only", cnt, 0);
    clr = 0;

    // Randomized traffic.
    act = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!act && $urandom_range(0, 2) == 0) begin
        act = 1;
        m_adr = pick_addr(); m_we = 1'($urandom);
        m_wd = $urandom; m_sel = 4'($urandom);
      end else if (act && (m_ack || m_err)) begin
        if ($urandom_range(0, 1) == 0) act = 0;
        else m_adr = pick_addr();
      end else if (act && $urandom_range(0, 29) == 0) begin
        act = 0;
      end
      m_cyc = act;
      m_stb = act && ($urandom_range(0, 7) != 0);
      for (int i = 0; i < N; i++) begin
        t_ack[i]  = ($urandom_range(0, 2) == 0);
        t_iena[i] = ($urandom_range(0, 15) != 0);
      end
      t_rd = {$urandom, $urandom, $urandom};
      clr = ($urandom_range(0, 59) == 0);
      rst = ($urandom_range(0, 699) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
